lc3b_mem_ctrl: RTL

Memory controller for the LC-3b core. It sits directly downstream of the datapath and consumes its MAR, MDR, MIO_EN, R_W and DATA_SIZE outputs. It runs a fixed-latency, byte-addressable memory access and returns the read word for the MDR, plus the ready (R) flag that the microsequencer polls in its memory-wait states. It owns the backing storage, the byte-lane write masking and the access timing. It has no bus arbitration.

---
 rtl/lc3b_pkg.sv | 10 +
 rtl/lc3b_mem_bank.sv | 23 ++
 rtl/lc3b_mem_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/lc3b_pkg.sv
// lc3b_pkg: shared state encoding, access constants and latency limits for the LC-3b memory controller.
package lc3b_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 15;
endpackage

// File: rtl/lc3b_mem_bank.sv
// lc3b_mem_bank: two byte-lane arrays with per-lane write enables and a registered aligned-word read.
module lc3b_mem_bank #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [7:0] lo [2**AW];
  logic [7:0] hi [2**AW];
  // storage is deliberately left out of reset; only the read register clears
  always_ff @(posedge clk) begin
    if (we_lo) lo[waddr] <= wdata[7:0];
    if (we_hi) hi[waddr] <= wdata[15:8];
    if (!rst) rdata <= 16'h0000;
    else if (re) rdata <= {hi[waddr], lo[waddr]};
  end
endmodule

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl: fixed-latency byte-addressable LC-3b memory with ready pulse.
// Optional unaligned-word trap enabled by defining LC3B_UNALIGNED_EXC_EN.
module lc3b_mem_ctrl
  import lc3b_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        r,
  output logic        busy,
  output logic        unaligned
);
  localparam logic [3:0] CNT0 = 4'(LATENCY > LATENCY_MIN ? LATENCY - 3 : 0);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] a, ca;
  logic [15:0] wd, cw;
  logic rw, sz, crw, csz, go, unal_in, acc;
  assign go = state == IDLE && mio_en;
`ifdef LC3B_UNALIGNED_EXC_EN
  assign unal_in = go && data_size == SIZE_WORD && addr[0];
`else
  assign unal_in = 1'b0;
`endif
  // with LATENCY=2 the access happens on the acceptance edge, so live inputs feed the array
  always_comb begin
    ca = state == IDLE ? addr[ADDR_W-1:0] : a;
    cw = state == IDLE ? wdata : wd;
    crw = state == IDLE ? r_w : rw;
    csz = state == IDLE ? data_size : sz;
    acc = rst && ((state == WAIT && mio_en && cnt == 4'd0) || (go && LATENCY == LATENCY_MIN && !unal_in));
    nxt = state == IDLE ? (mio_en ? ((LATENCY == LATENCY_MIN || unal_in) ? DONE : WAIT) : IDLE) :
          state == WAIT ? (!mio_en ? IDLE : (cnt == 4'd0 ? DONE : WAIT)) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      r <= 1'b0;
      busy <= 1'b0;
      unaligned <= 1'b0;
    end else begin
      state <= nxt;
      r <= nxt == DONE;
      busy <= nxt != IDLE;
      unaligned <= unal_in;
      if (go) begin
        a <= addr[ADDR_W-1:0];
        wd <= wdata;
        rw <= r_w;
        sz <= data_size;
        cnt <= CNT0;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
  lc3b_mem_bank #(.AW(ADDR_W-1)) u_bank (
    .clk(clk),
    .rst(rst),
    .re(acc && crw == RW_READ),
    .we_lo(acc && crw == RW_WRITE && (csz == SIZE_WORD || !ca[0])),
    .we_hi(acc && crw == RW_WRITE && (csz == SIZE_WORD || ca[0])),
    .waddr(ca[ADDR_W-1:1]),
    .wdata(cw),
    .rdata(rdata)
  );
endmodule
